// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a register-file write port.
module mdu_iter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic                  busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;     // product high half / partial remainder
  logic [W-1:0]  lo_q, lo_d;       // multiplier -> product low / dividend -> quotient
  logic [W-1:0]  opb_q, opb_d;     // multiplicand / divisor magnitude
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          neg_q, neg_d;     // sign of the selected result
  logic [W-1:0]  wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          valid_q, valid_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;

  logic          accept, is_div, is_rem, sgn1, sgn2, neg1, neg2;
  logic          div_zero, div_ovf;
  logic [W-1:0]  mag1, mag2, spec_res;
  logic [W:0]    mul_sum, div_shift, div_trial;

  // Operand decode, iteration datapath and next-state selection
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    accept    = in_valid && rdy_q && !flush;
    is_div    = op[2];
    is_rem    = op[2] && op[1];
    sgn1      = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn2      = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg1      = sgn1 && src1[W-1];
    neg2      = sgn2 && src2[W-1];
    mag1      = neg1 ? (~src1 + W'(1)) : src1;
    mag2      = neg2 ? (~src2 + W'(1)) : src2;
    div_zero  = is_div && (src2 == '0);
    div_ovf   = is_div && !op[0] && (src1 == MIN_NEG) && (src2 == '1);
    spec_res  = div_zero ? (is_rem ? src1 : '1) : (is_rem ? '0 : src1);
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, lo_q[W-1]};
    div_trial = div_shift - {1'b0, opb_q};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op;
          waddr_d = rd;
          cnt_d   = CW'(W);
          acc_d   = '0;
          lo_d    = mag1;
          opb_d   = mag2;
          if (is_div) neg_d = is_rem ? neg1 : (neg1 ^ neg2);
          else        neg_d = (op == 3'b000) ? 1'b0 : (neg1 ^ neg2);
          if (div_zero || div_ovf) begin
            wdata_d = spec_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          if (!div_trial[W]) begin
            acc_d = div_trial[W-1:0];
            lo_d  = {lo_q[W-2:0], 1'b1};
          end else begin
            acc_d = div_shift[W-1:0];
            lo_d  = {lo_q[W-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[W:1];
          lo_d  = {mul_sum[0], lo_q[W-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          3'b000:                 wdata_d = lo_q;
          3'b001, 3'b010, 3'b011: wdata_d = neg_q ? (~acc_q + W'(lo_q == '0)) : acc_q;
          3'b100, 3'b101:         wdata_d = neg_q ? (~lo_q + W'(1)) : lo_q;
          default:                wdata_d = neg_q ? (~acc_q + W'(1)) : acc_q;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;

    valid_d = (state_d == S_DONE);
    rdy_d   = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign wdata     = wdata_q;
  assign waddr     = waddr_q;
  // Write strobe: a flush cycle never writes, and x0 is never written
  assign wen       = valid_q && out_ready && (waddr_q != '0) && !flush;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed RV32M vectors plus random ops against a
// 64-bit arithmetic reference, with backpressure, flush and reset cases.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wen;
  logic        busy;

  int total = 0;
  int bad = 0;

  mdu_iter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .rd(rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .wdata(wdata),
    .waddr(waddr), .wen(wen), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // One complete operation: accept, latency, result, backpressure, retire
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input int hold);
    logic [31:0] exp;
    int k;
    int exp_lat;
    exp = ref_res(o, a, b);
    exp_lat = is_special(o, a, b) ? 0 : 33;
    @(negedge clk);
    chk("in_ready_pre", 64'(in_ready), 64'(1));
    in_valid = 1'b1; op = o; src1 = a; src2 = b; rd = r; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); src1 = $urandom; src2 = $urandom; rd = 5'($urandom);
    k = 0;
    while (out_valid !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("latency op%0d", o), 64'(k), 64'(exp_lat));
    chk($sformatf("wdata op%0d a=%h b=%h", o, a, b), 64'(wdata), 64'(exp));
    chk("waddr", 64'(waddr), 64'(r));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_wdata", 64'(wdata), 64'(exp));
      chk("bp_waddr", 64'(waddr), 64'(r));
      chk("bp_wen", 64'(wen), 64'(0));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("wen_pulse", 64'(wen), 64'(r != 0));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid), 64'(0));
    chk("post_in_ready", 64'(in_ready), 64'(1));
    chk("post_wen", 64'(wen), 64'(0));
  endtask

  initial begin
    int seen;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_waddr", 64'(waddr), 64'(0));
    chk("rst_wen", 64'(wen), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply vectors
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 0);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
    // Divide vectors
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 0);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 0);
    run(3'd5, 32'd100, 32'd7, 5'd11, 0);
    run(3'd7, 32'd100, 32'd7, 5'd12, 0);
    // Special cases
    run(3'd5, 32'd123, 32'd0, 5'd13, 0);
    run(3'd6, 32'd123, 32'd0, 5'd14, 0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0);
    // Backpressure and rd=0
    run(3'd0, 32'd1234, 32'd5678, 5'd17, 5);
    run(3'd4, 32'd50, 32'd0, 5'd18, 3);
    run(3'd0, 32'd9, 32'd9, 5'd0, 2);

    // Flush at T+10 of a DIV
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; src1 = 32'd1000; src2 = 32'd3; rd = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("flush_no_result", 64'(seen), 64'(0));
    out_ready = 1'b0;
    run(3'd0, 32'd3, 32'd4, 5'd4, 0);

    // Flush while a result is waiting: no write that cycle
    @(negedge clk);
    in_valid = 1'b1; op = 3'd5; src1 = 32'd5; src2 = 32'd0; rd = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fd_valid", 64'(out_valid), 64'(1));
    @(negedge clk);
    out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("fd_wen", 64'(wen), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("fd_valid_after", 64'(out_valid), 64'(0));
    chk("fd_in_ready", 64'(in_ready), 64'(1));

    // Request with flush in IDLE is dropped
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 3'd5; src2 = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'(0));
    chk("flush_idle_valid", 64'(out_valid), 64'(0));

    // Async reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; src1 = 32'd5; src2 = 32'd6; rd = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_wdata", 64'(wdata), 64'(0));
    chk("arst_waddr", 64'(waddr), 64'(0));
    chk("arst_wen", 64'(wen), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(3'd0, 32'd5, 32'd6, 5'd7, 0);

    // Random operations
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'($urandom_range(0, 300));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run(ro, ra, rb, 5'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Takes the two source-operand values read from the register file, plus the destination index and funct3.
- Computes over multiple cycles, one bit per cycle.
- Drives wen/waddr/wdata straight into the register file's write port with a valid/ready handshake toward writeback arbitration.

Parameters:
- DATA_WIDTH, 32, operand/result width (W)
- ADDR_WIDTH, 5, register index width

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept; = (state==IDLE)
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  input  DATA_WIDTH  rs1 value (register file rdata1)
- src2  input  DATA_WIDTH  rs2 value (register file rdata2)
- rd  input  ADDR_WIDTH  destination register index
- flush  input  1  synchronous abort of any in-flight op
- out_valid  output  1  result available
- out_ready  input  1  writeback accepts result
- wdata  output  DATA_WIDTH  result to register file
- waddr  output  ADDR_WIDTH  captured rd
- wen  output  1  out_valid && out_ready && waddr!=0
- busy  output  1  state!=IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; all internal regs, wdata, waddr = 0; out_valid=0, wen=0, busy=0; in_ready=1.
- FSM states: IDLE, CALC, FIX, DONE.
- Accept: handshake occurs when in_valid && in_ready at a posedge (cycle T). It captures op, rd, |src1|, |src2| (magnitudes only for signed operands, per op), the result-sign flag and the iteration counter=W.
- IDLE->CALC on accept (normal case).
- Special cases on accept go IDLE->DONE directly, out_valid in cycle T+1:
  - Divisor zero: DIV/DIVU quotient = all ones; REM/REMU = src1.
  - Signed overflow (DIV/REM with src1=0x80000000, src2=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Multiply in CALC:
  - Radix-2 shift-add on a 2W-bit product register, one multiplier bit per cycle.
  - MUL returns low W bits; MULH/MULHSU/MULHU return high W bits.
  - MULHSU treats src1 signed, src2 unsigned.
- Divide in CALC:
  - Restoring division, one quotient bit per cycle, W+1-bit partial remainder.
  - Quotient sign = sign1 XOR sign2; remainder sign = sign of dividend.
- CALC runs exactly W cycles (T+1..T+W), then FIX at T+W+1.
- FIX: two's-complement negation of the selected result if its sign flag is set. Result registered into wdata; go DONE.
- DONE: out_valid=1 from cycle T+W+2; wdata/waddr held stable until out_ready. Handshake -> IDLE next cycle.
- No same-cycle accept on DONE->IDLE; minimum op spacing is W+3 cycles (normal) or 2 cycles (special).
- wen is combinational; rd=0 completes the handshake normally with wen=0.
- flush (highest priority after reset) in any state:
  - Next state IDLE; out_valid=0 the following cycle.
  - No wen is generated in the flush cycle even if out_ready=1.
  - A request presented with flush in IDLE is not accepted.
- Reset asserted mid-operation: immediate return to reset values; no partial result is ever output.
- Inputs src1/src2/op/rd are ignored outside the accept cycle (may change freely).

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD (-3), rd=5, out_ready=1, accept at T: out_valid exactly at T+34, wdata=0xFFFFFFEB, waddr=5, wen=1 for one cycle. Also MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; all at T+34.
- DIVU 123/0 -> 0xFFFFFFFF at T+1; REM 123/0 -> 123; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid: wdata/waddr stable, wen=0, in_ready=0. Then out_ready=1 gives a single wen pulse, and in_ready=1 the next cycle. Separately, rd=0 gives a handshake with wen=0.
- Flush at cycle T+10 of a DIV: out_valid stays 0, busy=0 and in_ready=1 at T+11. A new MUL 3*4 accepted afterwards returns 12.
- Deassert rst_n asynchronously mid-CALC (between clock edges): outputs drop to reset values immediately. After release, a fresh op completes with correct latency and result.
